// File: rtl/fp_accumulator.sv
// fp_accumulator: packet accumulator wrapped around a combinational FP adder.
// Takes a stream of operands, feeds the adder from registered acc/operand values,
// folds the adder's sum back into acc and reports the packet total with sticky
// flags and a saturating element count.
module fp_accumulator #(
  parameter int unsigned EXP_WIDTH      = 8,
  parameter int unsigned MANTISSA_WIDTH = 23,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] data_in,
  input  logic                              data_valid_in,
  input  logic                              data_last_in,
  output logic                              data_ready_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0] add_a_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0] add_b_out,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] add_sum_in,
  input  logic                              add_ovf_in,
  input  logic                              add_unf_in,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0] sum_out,
  output logic                              sum_valid_out,
  input  logic                              sum_ready_in,
  output logic [COUNT_WIDTH-1:0]            count_out,
  output logic                              overflow_out,
  output logic                              underflow_out
);

  localparam int unsigned W = EXP_WIDTH + MANTISSA_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StAccum, StAdd, StDone} state_e;

  state_e                 state_q, state_d;
  logic [W-1:0]           acc_q, acc_d;
  logic [W-1:0]           op_b_q, op_b_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   last_q, last_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic                   take;

  // Next-state logic; ready/valid decode from state only.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    op_b_d         = op_b_q;
    count_d        = count_q;
    last_d         = last_q;
    ovf_d          = ovf_q;
    unf_d          = unf_q;
    data_ready_out = (state_q == StIdle) || (state_q == StAccum);
    sum_valid_out  = (state_q == StDone);
    take           = data_valid_in && data_ready_out;
    unique case (state_q)
      StIdle: begin
        // First element bypasses the adder: it cannot add to a zero accumulator.
        if (take) begin
          acc_d   = data_in;
          count_d = COUNT_WIDTH'(1);
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = data_last_in ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (take) begin
          op_b_d  = data_in;
          last_d  = data_last_in;
          state_d = StAdd;
        end
      end
      StAdd: begin
        acc_d   = add_sum_in;
        ovf_d   = ovf_q | add_ovf_in;
        unf_d   = unf_q | add_unf_in;
        count_d = (&count_q) ? count_q : count_q + COUNT_WIDTH'(1);
        state_d = last_q ? StDone : StAccum;
      end
      StDone: begin
        if (sum_ready_in) state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      acc_q   <= '0;
      op_b_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_b_q  <= op_b_d;
      count_q <= count_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Adder operands and results come straight from registers.
  always_comb begin
    add_a_out     = acc_q;
    add_b_out     = op_b_q;
    sum_out       = acc_q;
    count_out     = count_q;
    overflow_out  = ovf_q;
    underflow_out = unf_q;
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// Bench for fp_accumulator: directed vector table, reset/saturation sequences and
// randomized packets checked against a fold-over-elements reference model.
module tb_fp_accumulator;

  typedef struct packed {
    logic [3:0]       n;
    logic [7:0][31:0] el;
    logic [31:0]      sum;
    logic [15:0]      cnt;
    logic             ovf;
    logic             unf;
    logic [2:0]       hold;
  } vec_t;

  logic        clk, rst_n;
  logic [31:0] data;
  logic        valid, last, sum_ready;
  logic        ready1, sval1, ovf1, unf1, aovf1, aunf1;
  logic [31:0] a1, b1, s1, sum1;
  logic [15:0] cnt1;
  logic        ready2, sval2, ovf2, unf2, aovf2, aunf2;
  logic [31:0] a2, b2, s2, sum2;
  logic [1:0]  cnt2;

  int checks, failures;
  logic [4:0] rdy_pat;

  fp_accumulator u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(data), .data_valid_in(valid),
    .data_last_in(last), .data_ready_out(ready1), .add_a_out(a1), .add_b_out(b1),
    .add_sum_in(s1), .add_ovf_in(aovf1), .add_unf_in(aunf1), .sum_out(sum1),
    .sum_valid_out(sval1), .sum_ready_in(sum_ready), .count_out(cnt1),
    .overflow_out(ovf1), .underflow_out(unf1)
  );

  fp_accumulator #(.COUNT_WIDTH(2)) u_dut_sat (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(data), .data_valid_in(valid),
    .data_last_in(last), .data_ready_out(ready2), .add_a_out(a2), .add_b_out(b2),
    .add_sum_in(s2), .add_ovf_in(aovf2), .add_unf_in(aunf2), .sum_out(sum2),
    .sum_valid_out(sval2), .sum_ready_in(sum_ready), .count_out(cnt2),
    .overflow_out(ovf2), .underflow_out(unf2)
  );

  // Stand-in adder for positive normals (truncating). Underflow is a test hook:
  // raised whenever operand b's low byte is 8'h5A.
  function automatic logic [33:0] bench_add(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb, et;
    logic [24:0] ma, mb, mt, s;
    logic [8:0]  e;
    logic        o, u;
    logic [31:0] r;
    int          d;
    ea = a[30:23]; eb = b[30:23];
    ma = {2'b01, a[22:0]}; mb = {2'b01, b[22:0]};
    if (ea < eb) begin
      et = ea; ea = eb; eb = et;
      mt = ma; ma = mb; mb = mt;
    end
    d  = int'(ea) - int'(eb);
    mb = (d > 24) ? 25'd0 : (mb >> d);
    s  = ma + mb;
    e  = {1'b0, ea};
    if (s[24]) begin
      s = s >> 1;
      e = e + 9'd1;
    end
    o = (e >= 9'd255);
    r = o ? {1'b0, 8'hFF, 23'h0} : {1'b0, e[7:0], s[22:0]};
    u = (b[7:0] == 8'h5A);
    return {o, u, r};
  endfunction

  always_comb {aovf1, aunf1, s1} = bench_add(a1, b1);
  always_comb {aovf2, aunf2, s2} = bench_add(a2, b2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Streams one packet with valid held high, checks latency, result, backpressure
  // stability and the handshake.
  task automatic run_packet(input vec_t v, input string name, input bit chk_sat);
    int   idx, guard, np;
    logic took;
    idx = 0; guard = 0; np = 0; rdy_pat = '0;
    while (idx < int'(v.n) && guard < 50) begin
      data  = v.el[idx];
      valid = 1'b1;
      last  = (idx == int'(v.n) - 1);
      took  = ready1;
      if (np < 5) rdy_pat[np] = ready1;
      np++;
      @(posedge clk); #1;
      if (took) begin
        if (idx == 0) begin
          chk({name, "_first_cnt"}, 32'(cnt1), 32'd1);
          chk({name, "_first_ovf_clr"}, 32'(ovf1), 32'd0);
        end
        idx++;
      end
      guard++;
    end
    valid = 1'b0; last = 1'b0; data = 32'hDEAD_BEEF;
    if (np < 5) rdy_pat[np] = ready1;
    if (guard >= 50) chk({name, "_elem_timeout"}, 32'(idx), 32'(v.n));
    if (v.n == 4'd1) begin
      chk({name, "_lat1_valid"}, 32'(sval1), 32'd1);
    end else begin
      chk({name, "_latn_early"}, 32'(sval1), 32'd0);
      @(posedge clk); #1;
      chk({name, "_latn_valid"}, 32'(sval1), 32'd1);
    end
    chk({name, "_sum"}, sum1, v.sum);
    chk({name, "_cnt"}, 32'(cnt1), 32'(v.cnt));
    chk({name, "_ovf"}, 32'(ovf1), 32'(v.ovf));
    chk({name, "_unf"}, 32'(unf1), 32'(v.unf));
    chk({name, "_done_ready"}, 32'(ready1), 32'd0);
    if (chk_sat) begin
      chk({name, "_sat_cnt"}, 32'(cnt2), 32'd3);
      chk({name, "_sat_sum"}, sum2, v.sum);
    end
    for (int k = 0; k < int'(v.hold); k++) begin
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, 32'(sval1), 32'd1);
      chk({name, "_hold_sum"}, sum1, v.sum);
      chk({name, "_hold_cnt"}, 32'(cnt1), 32'(v.cnt));
      chk({name, "_hold_ready"}, 32'(ready1), 32'd0);
    end
    sum_ready = 1'b1;
    @(posedge clk); #1;
    sum_ready = 1'b0;
    chk({name, "_post_valid"}, 32'(sval1), 32'd0);
    chk({name, "_post_ready"}, 32'(ready1), 32'd1);
    chk({name, "_post_cnt_kept"}, 32'(cnt1), 32'(v.cnt));
  endtask

  vec_t tbl[4];
  vec_t rv;
  logic [33:0] r;
  logic [31:0] tot;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; valid = 1'b0; last = 1'b0; sum_ready = 1'b0; data = '0;

    tbl[0] = '0; tbl[0].n = 4'd3;
    tbl[0].el[0] = 32'h3F80_0000; tbl[0].el[1] = 32'h4000_0000; tbl[0].el[2] = 32'h4040_0000;
    tbl[0].sum = 32'h40C0_0000; tbl[0].cnt = 16'd3;
    tbl[1] = '0; tbl[1].n = 4'd1; tbl[1].el[0] = 32'h4049_0FDB;
    tbl[1].sum = 32'h4049_0FDB; tbl[1].cnt = 16'd1;
    tbl[2] = '0; tbl[2].n = 4'd2; tbl[2].el[0] = 32'h7F7F_FFFF; tbl[2].el[1] = 32'h7F7F_FFFF;
    tbl[2].sum = 32'h7F80_0000; tbl[2].cnt = 16'd2; tbl[2].ovf = 1'b1;
    tbl[3] = '0; tbl[3].n = 4'd2; tbl[3].el[0] = 32'h3F80_0000; tbl[3].el[1] = 32'h3F80_0000;
    tbl[3].sum = 32'h4000_0000; tbl[3].cnt = 16'd2; tbl[3].hold = 3'd5;

    #2;
    chk("rst_valid", 32'(sval1), 32'd0);
    chk("rst_ready", 32'(ready1), 32'd1);
    chk("rst_cnt", 32'(cnt1), 32'd0);
    chk("rst_acc", a1, 32'd0);
    chk("rst_ovf", 32'(ovf1), 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      run_packet(tbl[i], $sformatf("vec%0d", i), 1'b0);
      if (i == 0) chk("vec0_ready_pattern", 32'(rdy_pat), 32'b01011);
    end

    // Asynchronous reset while in ADD.
    data = 32'h3F80_0000; valid = 1'b1; last = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midadd_ready_low", 32'(ready1), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midadd_rst_valid", 32'(sval1), 32'd0);
    chk("midadd_rst_cnt", 32'(cnt1), 32'd0);
    chk("midadd_rst_acc", a1, 32'd0);
    chk("midadd_rst_opb", b1, 32'd0);
    chk("midadd_rst_ready", 32'(ready1), 32'd1);
    valid = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_packet(tbl[3], "after_rst", 1'b0);

    // Five 1.0 elements: full-width count reaches 5, 2-bit count sticks at 3.
    rv = '0; rv.n = 4'd5;
    for (int k = 0; k < 5; k++) rv.el[k] = 32'h3F80_0000;
    rv.sum = 32'h40A0_0000; rv.cnt = 16'd5;
    run_packet(rv, "sat", 1'b1);

    // Random packets against a fold-over-elements model.
    for (int p = 0; p < 25; p++) begin
      rv = '0;
      rv.n = 4'($urandom_range(1, 6));
      rv.hold = 3'($urandom_range(0, 3));
      for (int k = 0; k < int'(rv.n); k++) begin
        rv.el[k] = {1'b0, 8'($urandom_range(120, 134)), 23'($urandom)};
        if ($urandom_range(0, 3) == 0) rv.el[k][7:0] = 8'h5A;
      end
      tot = rv.el[0];
      rv.cnt = 16'd1;
      for (int k = 1; k < int'(rv.n); k++) begin
        r = bench_add(tot, rv.el[k]);
        tot = r[31:0];
        rv.ovf = rv.ovf | r[33];
        rv.unf = rv.unf | r[32];
        rv.cnt = rv.cnt + 16'd1;
      end
      rv.sum = tot;
      run_packet(rv, $sformatf("rnd%0d", p), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
